sr_latch_ctrl: RTL
==================

// Module: sr_latch_ctrl
// PURPOSE
//  Sequences a bank of N cross-coupled NAND SR latches: two requesters issue set/reset ops,
//  block arbitrates round-robin, drives one active-low sbar/rbar pulse of fixed width, then
//  a settle gap. Guarantees sbar[i] and rbar[i] are never low together (forbidden SR state).
//  Sits between control logic and the latch bank; latch q outputs are fed back for readback.
// PARAMETERS
//  N        8  number of latches in the bank
//  IDXW     3  index width, $clog2(N)
//  PULSE_W  2  cycles sbar/rbar held low per op (>=1)
//  SETTLE_W 1  cycles all lines high after a pulse, before next grant (>=1)
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     asynchronous, active-high reset
//  a_valid  in   1     requester A op valid
//  a_ready  out  1     A op accepted this cycle (valid&ready)
//  a_idx    in   IDXW  A target latch
//  a_set    in   1     A op: 1=set (pulse sbar), 0=reset (pulse rbar)
//  b_valid/b_ready/b_idx/b_set     same as A, requester B
//  sbar     out  N     active-low set lines to latch bank
//  rbar     out  N     active-low reset lines to latch bank
//  q_in     in   N     latch Q feedback (asynchronous source; 2-flop synchronised inside)
//  busy     out  1     FSM not IDLE
//  err      out  1     sticky readback mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: sbar=all 1, rbar=all 1, a_ready=b_ready=0, busy=0, err=0, FSM=IDLE, RR pointer=A.
//  FSM: IDLE -> PULSE (PULSE_W cyc) -> SETTLE (SETTLE_W cyc) -> [CHECK (1 cyc)] -> IDLE.
//  IDLE: if any valid, grant one; ready pulses 1 cycle for granted side only; idx/op latched.
//   Both valid: grant side pointed to by RR pointer; pointer flips to other side after grant.
//   One valid: granted regardless of pointer; pointer flips to the other side.
//  PULSE: registered outputs; exactly bit idx of sbar (set) or rbar (reset) low, first cycle
//   after grant; all other bits high. Only one bit of sbar|rbar ever low in any cycle.
//  SETTLE: all lines high. No grant in PULSE/SETTLE/CHECK: ready=0, requesters hold valid.
//  Throughput: one op per 1+PULSE_W+SETTLE_W(+1) cycles; grant-to-pulse latency 1 cycle.
//  idx >= N: accepted, no pulse (all lines stay high), FSM still walks PULSE/SETTLE.
//  Same idx, opposite ops from A and B together: serialised by RR; last op wins at latch.
//  Counter: single down-counter, width $clog2(max(PULSE_W,SETTLE_W))+1, reloaded per state.
//  rst mid-pulse: lines return high asynchronously; latch keeps whatever it captured.
// CONFIGURATION
//  `SR_LATCH_CTRL_READBACK_EN defined: CHECK state present; compares synchronised q_in[idx]
//   to op (set->1, reset->0); mismatch sets err, cleared only by rst. idx>=N never errors.
//  Not defined: no CHECK state, no synchroniser, err tied 0, SETTLE -> IDLE directly.
// STRUCTURE
//  Package sr_ctrl_pkg: state enum {IDLE,PULSE,SETTLE,CHECK}, op constants OP_SET=1/OP_RST=0,
//   requester id constants REQ_A=0/REQ_B=1.
//  Sub-module sr_rr_arb2: 2-way round-robin arbiter (valids, advance -> one-hot grant, ptr).
//  Top holds FSM, counter, op/idx registers, sbar/rbar decode, optional readback logic.
// TESTING (PULSE_W=2, SETTLE_W=1, N=8)
//  1. rst=1 for 3 cycles, release -> sbar=8'hFF, rbar=8'hFF, busy=0, err=0, readies 0.
//  2. A: idx=3,set=1 one op -> a_ready 1 cycle; next 2 cycles sbar=8'hF7; 1 cycle all high;
//     model latch q[3]=1.
//  3. A idx=1 set and B idx=1 reset both valid -> A granted first (sbar[1] low 2 cyc), then B
//     (rbar[1] low 2 cyc); final q[1]=0; sbar[1]&rbar[1] never both 0 (assertion every cycle).
//  4. A held valid continuously, B valid once -> grants alternate A,B,A; no starvation.
//  5. READBACK_EN: latch model stuck at 0, op idx=5 set -> err=1 after CHECK, stays 1 until rst.
//  6. rst asserted during PULSE with sbar=8'hFB -> sbar=8'hFF same cycle (async), FSM IDLE.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch bank controller.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the side that wins a tie and
// flips to the side opposite the winner whenever a grant is taken.
module sr_rr_arb2
  import sr_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q, ptr_d;

  // Grant selection and pointer update
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0] ? REQ_B : REQ_A;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a bank of NAND SR latches: arbitrates two requesters, drives one
// active-low sbar/rbar pulse, then a settle gap. Optional readback check of the
// latch Q outputs is enabled with `SR_LATCH_CTRL_READBACK_EN.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned IDXW     = $clog2(N),
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned SETTLE_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [IDXW-1:0] a_idx,
  input  logic            a_set,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [IDXW-1:0] b_idx,
  input  logic            b_set,
  output logic [N-1:0]    sbar,
  output logic [N-1:0]    rbar,
  input  logic [N-1:0]    q_in,
  output logic            busy,
  output logic            err
);

  localparam int unsigned MAXW = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int unsigned CNTW = $clog2(MAXW) + 1;
  localparam logic [CNTW-1:0] PULSE_LOAD  = CNTW'(PULSE_W - 1);
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_W - 1);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              op_q, op_d;
  logic              hit_q, hit_d;
  logic [N-1:0]      sbar_q, sbar_d;
  logic [N-1:0]      rbar_q, rbar_d;
  logic [N-1:0]      sel;
  logic              pulse_on;
  logic [1:0]        grant;
  logic              in_idle;
  logic              rr_ptr_unused;

  // Single low bit for an in-range index, nothing otherwise
  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] i, input logic h);
    logic [N-1:0] m;
    m = {{(N-1){1'b0}}, 1'b1} << i;
    return h ? m : '0;
  endfunction

  assign in_idle = (state_q == IDLE);

  sr_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({b_valid, a_valid}),
    .advance (in_idle),
    .grant   (grant),
    .ptr     (rr_ptr_unused)
  );

  assign a_ready = in_idle & grant[0];
  assign b_ready = in_idle & grant[1];

  // Next-state, counter reload and line decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    op_d     = op_q;
    hit_d    = hit_q;
    pulse_on = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          idx_d    = grant[1] ? b_idx : a_idx;
          op_d     = grant[1] ? b_set : a_set;
          hit_d    = 32'(idx_d) < N;
          state_d  = PULSE;
          cnt_d    = PULSE_LOAD;
          pulse_on = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d    = cnt_q - CNTW'(1);
          pulse_on = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
`ifdef SR_LATCH_CTRL_READBACK_EN
          state_d = CHECK;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Only one of sbar/rbar can ever carry the low bit, so the forbidden state is unreachable
    sel    = pulse_on ? onehot(idx_d, hit_d) : '0;
    sbar_d = ~((op_d == OP_SET) ? sel : '0);
    rbar_d = ~((op_d == OP_RST) ? sel : '0);
  end

  // State, counter, op and registered line drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= OP_RST;
      hit_q   <= 1'b0;
      sbar_q  <= '1;
      rbar_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      hit_q   <= hit_d;
      sbar_q  <= sbar_d;
      rbar_q  <= rbar_d;
    end
  end

  assign sbar = sbar_q;
  assign rbar = rbar_q;
  assign busy = ~in_idle;

`ifdef SR_LATCH_CTRL_READBACK_EN
  logic [N-1:0] q_meta, q_sync;
  logic         err_q;
  logic         mism;

  assign mism = (state_q == CHECK) && hit_q &&
                ((|(q_sync & onehot(idx_q, 1'b1))) != op_q);

  // Two-flop synchroniser for latch Q feedback and sticky mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta <= '0;
      q_sync <= '0;
      err_q  <= 1'b0;
    end else begin
      q_meta <= q_in;
      q_sync <= q_meta;
      err_q  <= err_q | mism;
    end
  end

  assign err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign err = 1'b0;
`endif

endmodule
